fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-side controller of the asynchronous FIFO, running entirely in the write clock domain. It accepts write requests, generates the memory write address and enable, and maintains the binary and Gray write pointers. It also derives full, almost-full and overflow status by comparing its pointer with the read pointer synchronized into the write domain. Its Gray pointer output feeds the write-to-read synchronizer, whose output drives the read-side controller's empty logic.

## Interface

Parameters:
- number_of_bit_address, default 4: address width; FIFO depth = 2^number_of_bit_address; pointers are number_of_bit_address+1 bits.
- almost_full_threshold, default 14: occupancy at or above which walmost_full asserts; legal range 1..depth.

Ports (A = number_of_bit_address):
- wclk  input  1  write-domain clock; all state changes on its rising edge.
- wrst_n  input  1  asynchronous active-low reset.
- winc  input  1  write request for the current cycle.
- wq2_rptr  input  A+1  read pointer in Gray code, already double-flop synchronized into wclk.
- wovf_clr  input  1  synchronous clear of the sticky overflow flag.
- wclken  output  1  combinational memory write enable = winc & ~wfull.
- waddr  output  A  registered memory write address.
- wptr  output  A+1  registered Gray write pointer, to the synchronizer.
- wfull  output  1  registered full flag.
- walmost_full  output  1  registered almost-full flag.
- woverflow  output  1  sticky flag: a write was attempted while full.
- wcount  output  A+1  registered occupancy as seen from the write domain (0..depth).

## Operation

- Reset, asynchronous on wrst_n low: internal binary pointer wbin=0, waddr=0, wptr=0, wfull=0, walmost_full=0, woverflow=0, wcount=0. wclken follows its equation.
- Write acceptance: a write is accepted when winc=1 and wfull=0. An attempted write while full is dropped: no pointer or address change, and woverflow is set.
- Next-state values:
  - wbin_next = wbin + (winc & ~wfull), modulo 2^(A+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- Registered updates each edge:
  - wbin <= wbin_next.
  - waddr <= wbin_next[A-1:0].
  - wptr <= wgray_next.
- Full: wfull <= (wgray_next == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), i.e. the top two Gray bits are inverted and the rest are equal.
- Occupancy:
  - rbin_sync = Gray-to-binary of wq2_rptr, combinational XOR-prefix from the MSB.
  - wcount <= wbin_next - rbin_sync, modulo 2^(A+1). The result never exceeds depth in legal operation.
- Almost-full: walmost_full <= ((wbin_next - rbin_sync) >= almost_full_threshold).
- Overflow: woverflow <= wovf_clr ? 0 : (woverflow | (winc & wfull)). If clear and a new overflow occur in the same cycle, clear wins.
- Wrap-around: the pointer rolls over from 2^(A+1)-1 to 0 and waddr from 2^A-1 to 0, with no special handling. The extra MSB distinguishes full from empty.
- wptr is driven directly from a register: no combinational path to the synchronizer, and only one Gray bit changes per edge.

## Timing

- Accepted write at edge N:
  - waddr, wptr and wcount reflect the increment after edge N.
  - The memory writes data at the old waddr on edge N, using wclken.
- wfull asserts on the same edge as the write that fills the FIFO. The next cycle's winc is then blocked.
- wfull deasserts one edge after wq2_rptr changes. Full release is pessimistic by synchronizer latency plus one cycle; this is required and safe.
- walmost_full and wcount carry the same one-edge latency relative to wq2_rptr.
- Simultaneous events:
  - winc while a wq2_rptr change arrives: both are taken into account in the same next-state computation.
  - winc while wfull=1 and the read side is freeing space: the write is still blocked that cycle.
- Reset asserted mid-operation clears all state immediately, independent of wclk. Outputs hold reset values until the first rising edge after wrst_n rises.

## Test plan

- Reset: assert wrst_n=0 mid-burst -> wptr=0, waddr=0, wfull=0, walmost_full=0, woverflow=0, wcount=0 immediately.
- Fill (A=4, wq2_rptr=0): 16 consecutive winc -> after the 16th edge, wbin=16, wptr=5'b11000, waddr=0, wfull=1, wcount=16. walmost_full rises after the 14th write.
- Overflow: with full, winc=1 for 2 cycles -> wptr stays 5'b11000, wclken=0, woverflow=1 and stays set. Pulse wovf_clr -> woverflow=0 next edge.
- Release: from full, step wq2_rptr to 5'b00001 -> wfull=0 and wcount=15 one edge later; one write is accepted and wfull returns to 1.
- Wrap: continuous write/read traffic through 40 writes, with wq2_rptr tracking -> wptr follows Gray of (count mod 32), waddr = count mod 16, and no false wfull.
- Simultaneous: winc=1 on the same cycle as wq2_rptr advances from full (0 -> 1) -> the write is blocked that cycle and accepted the following cycle.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller of an asynchronous FIFO, fully in the wclk domain.
// Accepts write requests, produces the memory write address/enable, keeps the
// binary and Gray write pointers, and derives full / almost-full / overflow /
// occupancy status against the read pointer synchronized into wclk.
//
// Ports (A = number_of_bit_address):
//   wclk         in   1    write clock, all state changes on its rising edge
//   wrst_n       in   1    asynchronous active-low reset
//   winc         in   1    write request for the current cycle
//   wq2_rptr     in   A+1  read pointer (Gray), already synchronized into wclk
//   wovf_clr     in   1    synchronous clear of the sticky overflow flag
//   wclken       out  1    memory write enable = winc & ~wfull (combinational)
//   waddr        out  A    registered memory write address
//   wptr         out  A+1  registered Gray write pointer, to the synchronizer
//   wfull        out  1    registered full flag
//   walmost_full out  1    registered almost-full flag
//   woverflow    out  1    sticky: a write was attempted while full
//   wcount       out  A+1  registered occupancy seen from the write domain
// -----------------------------------------------------------------------------
module fifo_wr_ctrl #(
    parameter int number_of_bit_address = 4,
    parameter int almost_full_threshold = 14
) (
    input  logic                             wclk,
    input  logic                             wrst_n,
    input  logic                             winc,
    input  logic [number_of_bit_address:0]   wq2_rptr,
    input  logic                             wovf_clr,
    output logic                             wclken,
    output logic [number_of_bit_address-1:0] waddr,
    output logic [number_of_bit_address:0]   wptr,
    output logic                             wfull,
    output logic                             walmost_full,
    output logic                             woverflow,
    output logic [number_of_bit_address:0]   wcount
);

    localparam int A  = number_of_bit_address;
    localparam int PW = A + 1;
    localparam logic [PW-1:0] AF_THRESH = PW'(almost_full_threshold);

    // Binary to Gray conversion.
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: XOR prefix running down from the MSB.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_q,  wbin_d;
    logic [A-1:0]  waddr_q, waddr_d;
    logic [PW-1:0] wptr_q,  wptr_d;
    logic          wfull_q, wfull_d;
    logic          walmost_full_q, walmost_full_d;
    logic          woverflow_q, woverflow_d;
    logic [PW-1:0] wcount_q, wcount_d;
    logic [PW-1:0] rbin_sync_s;
    logic [PW-1:0] full_cmp_s;
    logic          wen_s;

    // Next-state computation for pointers and status flags.
    always_comb begin
        wen_s       = winc & ~wfull_q;
        rbin_sync_s = gray2bin(wq2_rptr);
        // Full when our next Gray pointer equals the read pointer with the
        // top two Gray bits inverted (one full lap ahead).
        full_cmp_s  = {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]};

        wbin_d         = wbin_q + {{A{1'b0}}, wen_s};
        waddr_d        = wbin_d[A-1:0];
        wptr_d         = bin2gray(wbin_d);
        wfull_d        = (wptr_d == full_cmp_s);
        wcount_d       = wbin_d - rbin_sync_s;
        walmost_full_d = (wcount_d >= AF_THRESH);
        // Clear takes priority over a coincident new overflow.
        if (wovf_clr) begin
            woverflow_d = 1'b0;
        end else begin
            woverflow_d = woverflow_q | (winc & wfull_q);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= {PW{1'b0}};
            waddr_q        <= {A{1'b0}};
            wptr_q         <= {PW{1'b0}};
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
            wcount_q       <= {PW{1'b0}};
        end else begin
            wbin_q         <= wbin_d;
            waddr_q        <= waddr_d;
            wptr_q         <= wptr_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
            wcount_q       <= wcount_d;
        end
    end

    // Output drive: everything but the write enable comes straight from flops.
    always_comb begin
        wclken       = wen_s;
        waddr        = waddr_q;
        wptr         = wptr_q;
        wfull        = wfull_q;
        walmost_full = walmost_full_q;
        woverflow    = woverflow_q;
        wcount       = wcount_q;
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
// Directed self-checking bench for fifo_wr_ctrl with A=4, threshold 14.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       wovf_clr;
    logic       wclken;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic       woverflow;
    logic [4:0] wcount;

    int n_checks;
    int n_pass;

    fifo_wr_ctrl #(
        .number_of_bit_address(4),
        .almost_full_threshold(14)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .winc        (winc),
        .wq2_rptr    (wq2_rptr),
        .wovf_clr    (wovf_clr),
        .wclken      (wclken),
        .waddr       (waddr),
        .wptr        (wptr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .woverflow   (woverflow),
        .wcount      (wcount)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Compare one observed value against its expectation.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_reset_state(input string tag);
        check_val({tag, "_wptr"},  32'(wptr),         32'd0);
        check_val({tag, "_waddr"}, 32'(waddr),        32'd0);
        check_val({tag, "_wfull"}, 32'(wfull),        32'd0);
        check_val({tag, "_waf"},   32'(walmost_full), 32'd0);
        check_val({tag, "_wovf"},  32'(woverflow),    32'd0);
        check_val({tag, "_wcnt"},  32'(wcount),       32'd0);
    endtask

    logic [4:0] cnt;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wq2_rptr = 5'd0;
        wovf_clr = 1'b0;
        #3;
        check_reset_state("rst0");
        check_val("rst0_wclken", 32'(wclken), 32'd0);
        @(negedge wclk);
        wrst_n = 1'b1;

        // Short burst, then asynchronous reset mid-burst.
        winc = 1'b1;
        step(); step(); step();
        check_val("burst_wcnt",  32'(wcount), 32'd3);
        check_val("burst_waddr", 32'(waddr),  32'd3);
        check_val("burst_wptr",  32'(wptr),   32'd2);
        #2;
        wrst_n = 1'b0;
        #1;
        check_reset_state("rstmid");
        check_val("rstmid_wclken", 32'(wclken), 32'd1);
        winc = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;

        // Fill 16 entries with the read pointer parked at 0.
        winc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check_val($sformatf("fill%0d_wcnt", i), 32'(wcount), 32'(i));
            check_val($sformatf("fill%0d_waf", i), 32'(walmost_full), (i >= 14) ? 32'd1 : 32'd0);
            check_val($sformatf("fill%0d_wfull", i), 32'(wfull), (i == 16) ? 32'd1 : 32'd0);
        end
        check_val("full_wptr",   32'(wptr),   32'h18);
        check_val("full_waddr",  32'(waddr),  32'd0);
        check_val("full_wclken", 32'(wclken), 32'd0);

        // Attempted writes while full: dropped, overflow sticks.
        for (int i = 0; i < 2; i++) begin
            step();
            check_val($sformatf("ovf%0d_wptr", i), 32'(wptr),      32'h18);
            check_val($sformatf("ovf%0d_wen", i),  32'(wclken),    32'd0);
            check_val($sformatf("ovf%0d_flag", i), 32'(woverflow), 32'd1);
        end
        winc = 1'b0;
        step();
        check_val("ovf_sticky", 32'(woverflow), 32'd1);
        wovf_clr = 1'b1;
        step();
        check_val("ovf_clr", 32'(woverflow), 32'd0);
        // Clear and new overflow together: clear wins.
        winc = 1'b1;
        step();
        check_val("ovf_clr_wins", 32'(woverflow), 32'd0);
        wovf_clr = 1'b0;
        step();
        check_val("ovf_reset_again", 32'(woverflow), 32'd1);

        // Read pointer advances 0->1 on the same cycle as a write: blocked.
        wq2_rptr = 5'b00001;
        step();
        check_val("sim_wptr",  32'(wptr),   32'h18);
        check_val("sim_wfull", 32'(wfull),  32'd0);
        check_val("sim_wcnt",  32'(wcount), 32'd15);
        check_val("sim_wen",   32'(wclken), 32'd1);
        step();
        check_val("rel_wptr",  32'(wptr),   32'h19);
        check_val("rel_waddr", 32'(waddr),  32'd1);
        check_val("rel_wfull", 32'(wfull),  32'd1);
        check_val("rel_wcnt",  32'(wcount), 32'd16);
        check_val("rel_waf",   32'(walmost_full), 32'd1);

        // Drain: read pointer catches up with write pointer (binary 17).
        winc     = 1'b0;
        wq2_rptr = 5'b11001;
        step();
        check_val("drain_wfull", 32'(wfull),        32'd0);
        check_val("drain_wcnt",  32'(wcount),       32'd0);
        check_val("drain_waf",   32'(walmost_full), 32'd0);

        // Wrap traffic: reader trails the writer by one entry.
        cnt  = 5'd17;
        winc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wq2_rptr = gray5(cnt);
            step();
            cnt = cnt + 5'd1;
            check_val($sformatf("wrap%0d_wptr", i),  32'(wptr),   32'(gray5(cnt)));
            check_val($sformatf("wrap%0d_waddr", i), 32'(waddr),  32'(cnt[3:0]));
            check_val($sformatf("wrap%0d_wfull", i), 32'(wfull),  32'd0);
            check_val($sformatf("wrap%0d_wcnt", i),  32'(wcount), 32'd1);
        end
        winc = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
